seq_detect_ctrl: RTL and testbench
==================================

Name: seq_detect_ctrl

Overview:
- Programmable serial sequence-detection controller.
- Accepts parallel data words over a valid/ready handshake and serializes each word MSB-first through an internal PAT_W-bit pattern matcher (Mealy style), one bit per clock.
- Counts matches and raises a sticky interrupt at a programmed threshold.
- Sits between a word-oriented producer and the fixed-pattern detectors in the FSM library, acting as their configurable scheduler and front end.

Parameters:
DATA_W, 8, width of each input word
PAT_W, 4, pattern length in bits (2..DATA_W)
CNT_W, 8, width of match counter and threshold

Ports:
clk  in  1  clock, rising edge
reset_ah_in  in  1  asynchronous reset, active-low; port name kept per codebase naming
start  in  1  arm controller, latch config (honoured in IDLE only)
stop  in  1  disarm request
clr  in  1  clear match_cnt and irq
cfg_pattern  in  PAT_W  target pattern, MSB is first bit received
cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping
cfg_thresh  in  CNT_W  irq threshold; 0 disables irq
in_valid  in  1  input word valid
in_data  in  DATA_W  input word
in_ready  out  1  controller can accept a word
det_pulse  out  1  one-cycle match indication
match_cnt  out  CNT_W  saturating match count
irq  out  1  sticky threshold interrupt
busy  out  1  controller not in IDLE

Behaviour:
- Reset (reset_ah_in low, asynchronous):
  - state=IDLE; all outputs 0.
  - Shift register, history, bit counter, seen counter and latched config all cleared.
- FSM states: IDLE, WAIT, SHIFT.
- IDLE:
  - in_ready=0, busy=0.
  - On start=1: latch cfg_pattern, cfg_overlap and cfg_thresh; clear history and seen counter; go to WAIT next cycle.
  - start in any other state is ignored.
- WAIT:
  - in_ready=1.
  - If stop=1: go to IDLE (stop has priority over a simultaneous handshake; the word is not accepted).
  - Else, on in_valid & in_ready: load in_data into the shifter; bit index=DATA_W-1; go to SHIFT.
- SHIFT:
  - in_ready=0; each cycle consume one bit (MSB first).
  - After the last bit (index 0), go to WAIT, or to IDLE if a stop was seen during this word. stop is latched and does not abort the word.
  - Throughput: word accepted at edge t; bits processed in cycles t+1..t+DATA_W; in_ready high again in cycle t+DATA_W+1.
- Matching, per consumed bit b:
  - cand = {history[PAT_W-2:0], b}.
  - seen = min(seen+1, PAT_W).
  - match = (cand == latched pattern) && (seen == PAT_W).
  - history <= cand.
  - On match with overlap=0: seen <= 0 (next match needs PAT_W fresh bits). With overlap=1: seen is unchanged.
  - History and seen persist across word boundaries; patterns may span words.
  - Reset only by start or reset_ah_in.
- Outputs (registered):
  - det_pulse is high for exactly one cycle, the cycle after the matching bit.
  - match_cnt increments on the same edge and saturates at 2^CNT_W-1.
  - irq is set when the incremented value equals the latched thresh (thresh != 0); it stays set until clr.
  - clr=1 forces match_cnt=0 and irq=0. clr wins over a simultaneous increment; det_pulse still fires.
- busy=1 in WAIT and SHIFT.
- Config inputs are ignored outside IDLE.

Decomposition:
- Package seq_detect_pkg holds:
  - the state encoding constants (IDLE=0, WAIT=1, SHIFT=2; 2-bit);
  - default parameter values.
- One natural sub-module, seq_match_core: the history/seen/match logic with inputs bit_valid, bit, pattern, overlap, restart and output match. The controller instantiates it and owns the FSM, handshake, counter and irq.

Test Plan:
1. Non-overlap count: pattern=1010, overlap=0, thresh=0, start, send 0xAA → det_pulse twice (after bits 4 and 8), match_cnt=2, irq=0; in_ready returns 9 cycles after acceptance.
2. Overlap count: pattern=1010, overlap=1, send 0xAA → det_pulse after bits 4, 6, 8; match_cnt=3.
3. Cross-word match: pattern=1010, overlap=0, send 0x01 then 0x40 → exactly one det_pulse, on bit 3 of the second word; match_cnt=1.
4. Threshold and clear:
   - overlap=1, thresh=3, send 0xAA → irq rises with the third det_pulse and stays high.
   - Pulse clr → match_cnt=0, irq=0.
   - Send 0xAA again → irq=1.
5. Stop handling:
   - Assert stop one cycle into SHIFT → the full word is still processed; then IDLE, busy=0, in_ready=0.
   - stop and in_valid together in WAT... in WAIT → go to IDLE, word not accepted.
6. Async reset mid-SHIFT: drop reset_ah_in between edges → outputs 0 immediately. After release and start, 0xAA with overlap=0 gives match_cnt=2 (no stale history).

Source files
------------

// File: rtl/seq_detect_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_detect_pkg                                                       |
// | Shared state encoding and default sizes for the sequence detector.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package seq_detect_pkg;

  localparam int unsigned c_data_w_dflt = 8;
  localparam int unsigned c_pat_w_dflt  = 4;
  localparam int unsigned c_cnt_w_dflt  = 8;

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_wait  = 2'd1;
  localparam logic [1:0] c_st_shift = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = c_st_idle,
    ST_WAIT  = c_st_wait,
    ST_SHIFT = c_st_shift
  } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_detect_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_detect_ctrl_if                                                   |
// | Word valid/ready handshake from producer to the detector controller. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface seq_detect_ctrl_if
  import seq_detect_pkg::*;
#(
  parameter int DATA_W = c_data_w_dflt
);

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);

endinterface
`default_nettype wire

// File: rtl/seq_match_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_match_core                                                       |
// | Mealy bit-serial pattern matcher with overlap control.               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module seq_match_core
  import seq_detect_pkg::*;
#(
  parameter int PAT_W = c_pat_w_dflt
) (
  input  wire logic             clk,
  input  wire logic             reset_ah_in,
  input  wire logic             bit_valid,
  input  wire logic             bit_in,
  input  wire logic [PAT_W-1:0] pattern,
  input  wire logic             overlap,
  input  wire logic             restart,
  output logic                  match
);

  localparam int c_seen_w = $clog2(PAT_W + 1);
  localparam logic [c_seen_w-1:0] c_seen_full = c_seen_w'(PAT_W);

  logic [PAT_W-2:0]    r_hist;
  logic [c_seen_w-1:0] r_seen;
  logic [PAT_W-1:0]    w_cand;
  logic [c_seen_w-1:0] w_seen_nxt;

  assign w_cand     = {r_hist, bit_in};
  assign w_seen_nxt = (r_seen == c_seen_full) ? c_seen_full : r_seen + c_seen_w'(1);
  assign match      = bit_valid && (w_cand == pattern) && (w_seen_nxt == c_seen_full);

  // seen counts fresh bits; a non-overlapping hit forces PAT_W new bits before the next one
  always_ff @(posedge clk or negedge reset_ah_in) begin
    if (!reset_ah_in) begin
      r_hist <= '0;
      r_seen <= '0;
    end else if (restart) begin
      r_hist <= '0;
      r_seen <= '0;
    end else if (bit_valid) begin
      r_hist <= w_cand[PAT_W-2:0];
      r_seen <= (match && !overlap) ? '0 : w_seen_nxt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/seq_detect_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_detect_ctrl                                                      |
// | Word-to-bit scheduler, match counter and sticky threshold interrupt. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int DATA_W = c_data_w_dflt,
  parameter int PAT_W  = c_pat_w_dflt,
  parameter int CNT_W  = c_cnt_w_dflt
) (
  input  wire logic             clk,
  input  wire logic             reset_ah_in,
  input  wire logic             start,
  input  wire logic             stop,
  input  wire logic             clr,
  input  wire logic [PAT_W-1:0] cfg_pattern,
  input  wire logic             cfg_overlap,
  input  wire logic [CNT_W-1:0] cfg_thresh,
  seq_detect_ctrl_if.slave      in_if,
  output logic                  det_pulse,
  output logic [CNT_W-1:0]      match_cnt,
  output logic                  irq,
  output logic                  busy
);

  localparam int c_idx_w = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  state_t             r_state;
  logic [DATA_W-1:0]  r_shift;
  logic [c_idx_w-1:0] r_idx;
  logic               r_stop_seen;
  logic [PAT_W-1:0]   r_pat;
  logic               r_ovl;
  logic [CNT_W-1:0]   r_thresh;
  logic               r_in_ready;
  logic               r_busy;
  logic               r_det;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_irq;

  logic               w_bit_valid;
  logic               w_restart;
  logic               w_match;
  logic [CNT_W-1:0]   w_cnt_inc;

  assign w_bit_valid = (r_state == ST_SHIFT);
  assign w_restart   = (r_state == ST_IDLE) && start;
  assign w_cnt_inc   = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + CNT_W'(1);

  seq_match_core #(.PAT_W(PAT_W)) u_match (
    .clk        (clk),
    .reset_ah_in(reset_ah_in),
    .bit_valid  (w_bit_valid),
    .bit_in     (r_shift[DATA_W-1]),
    .pattern    (r_pat),
    .overlap    (r_ovl),
    .restart    (w_restart),
    .match      (w_match)
  );

  always_ff @(posedge clk or negedge reset_ah_in) begin
    if (!reset_ah_in) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_idx       <= '0;
      r_stop_seen <= 1'b0;
      r_pat       <= '0;
      r_ovl       <= 1'b0;
      r_thresh    <= '0;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_det       <= 1'b0;
      r_cnt       <= '0;
      r_irq       <= 1'b0;
    end else begin
      r_det <= w_match;
      if (clr) begin
        r_cnt <= '0;
        r_irq <= 1'b0;
      end else if (w_match) begin
        r_cnt <= w_cnt_inc;
        if ((r_thresh != '0) && (w_cnt_inc == r_thresh))
          r_irq <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_pat      <= cfg_pattern;
            r_ovl      <= cfg_overlap;
            r_thresh   <= cfg_thresh;
            r_state    <= ST_WAIT;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (stop) begin
            r_state    <= ST_IDLE;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
          end else if (in_if.in_valid) begin
            r_shift     <= in_if.in_data;
            r_idx       <= c_idx_w'(DATA_W - 1);
            r_stop_seen <= 1'b0;
            r_state     <= ST_SHIFT;
            r_in_ready  <= 1'b0;
          end
        end
        ST_SHIFT: begin
          // a stop during a word only takes effect once its last bit is consumed
          r_shift <= r_shift << 1;
          r_idx   <= r_idx - c_idx_w'(1);
          if (stop)
            r_stop_seen <= 1'b1;
          if (r_idx == '0) begin
            if (r_stop_seen || stop) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state    <= ST_WAIT;
              r_in_ready <= 1'b1;
            end
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign in_if.in_ready = r_in_ready;
  assign det_pulse      = r_det;
  assign match_cnt      = r_cnt;
  assign irq            = r_irq;
  assign busy           = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_seq_detect_ctrl                                                   |
// | Directed and randomized checks against a bit-stream reference model. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_seq_detect_ctrl;

  localparam int DATA_W = 8;
  localparam int PAT_W  = 4;
  localparam int CNT_W  = 8;
  localparam int c_cnt_max = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset_ah_in = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             clr = 1'b0;
  logic [PAT_W-1:0] cfg_pattern = '0;
  logic             cfg_overlap = 1'b0;
  logic [CNT_W-1:0] cfg_thresh = '0;
  logic             det_pulse;
  logic [CNT_W-1:0] match_cnt;
  logic             irq;
  logic             busy;

  seq_detect_ctrl_if #(.DATA_W(DATA_W)) in_if ();

  seq_detect_ctrl #(.DATA_W(DATA_W), .PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset_ah_in(reset_ah_in),
    .start      (start),
    .stop       (stop),
    .clr        (clr),
    .cfg_pattern(cfg_pattern),
    .cfg_overlap(cfg_overlap),
    .cfg_thresh (cfg_thresh),
    .in_if      (in_if),
    .det_pulse  (det_pulse),
    .match_cnt  (match_cnt),
    .irq        (irq),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: whole received bit stream since start, plus fresh-bit count
  int               m_cnt = 0;
  bit               m_irq = 1'b0;
  logic [PAT_W-1:0] m_pat = '0;
  bit               m_ovl = 1'b0;
  int               m_thr = 0;
  int               m_bits[$];
  int               m_fresh = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit model_bit(input int b);
    bit m;
    m_bits.push_back(b);
    m_fresh++;
    m = 1'b0;
    if (m_fresh >= PAT_W) begin
      m = 1'b1;
      for (int i = 0; i < PAT_W; i++)
        if (m_bits[m_bits.size() - PAT_W + i] != int'(m_pat[PAT_W-1-i])) m = 1'b0;
    end
    if (m && !m_ovl) m_fresh = 0;
    return m;
  endfunction

  task automatic model_edge(input bit m, input bit c);
    if (c) begin
      m_cnt = 0;
      m_irq = 1'b0;
    end else if (m) begin
      if (m_cnt < c_cnt_max) m_cnt++;
      if (m_thr != 0 && m_cnt == m_thr) m_irq = 1'b1;
    end
  endtask

  task automatic check_outs(input string tag, input bit e_det, input bit e_rdy, input bit e_busy);
    chk({tag, "_det"},  32'(det_pulse),      32'(e_det));
    chk({tag, "_cnt"},  32'(match_cnt),      32'(m_cnt));
    chk({tag, "_irq"},  32'(irq),            32'(m_irq));
    chk({tag, "_rdy"},  32'(in_if.in_ready), 32'(e_rdy));
    chk({tag, "_busy"}, 32'(busy),           32'(e_busy));
  endtask

  task automatic arm(input logic [PAT_W-1:0] pat, input bit ovl, input int thr);
    cfg_pattern = pat;
    cfg_overlap = ovl;
    cfg_thresh  = CNT_W'(thr);
    start = 1'b1;
    m_pat = pat; m_ovl = ovl; m_thr = thr;
    m_bits.delete();
    m_fresh = 0;
    model_edge(1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    cfg_pattern = PAT_W'($urandom);
    cfg_overlap = 1'($urandom);
    cfg_thresh  = CNT_W'($urandom);
    check_outs("arm", 1'b0, 1'b1, 1'b1);
  endtask

  task automatic wait_cycle(input int clr_rate);
    bit c;
    c = (clr_rate != 0) && ($urandom_range(clr_rate - 1) == 0);
    clr   = c;
    start = ($urandom_range(3) == 0);
    cfg_pattern = PAT_W'($urandom);
    model_edge(1'b0, c);
    @(negedge clk);
    clr = 1'b0; start = 1'b0;
    check_outs("wait", 1'b0, 1'b1, 1'b1);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    model_edge(1'b0, 1'b1);
    @(negedge clk);
    clr = 1'b0;
    chk("clr_cnt", 32'(match_cnt), 32'd0);
    chk("clr_irq", 32'(irq), 32'd0);
  endtask

  task automatic send_word(input logic [DATA_W-1:0] d, input bit stop_mid, input int clr_rate);
    bit mflags[DATA_W];
    bit c;
    chk("pre_rdy", 32'(in_if.in_ready), 32'd1);
    in_if.in_valid = 1'b1;
    in_if.in_data  = d;
    model_edge(1'b0, 1'b0);
    @(negedge clk);
    in_if.in_valid = 1'b0;
    in_if.in_data  = DATA_W'($urandom);
    check_outs("acc", 1'b0, 1'b0, 1'b1);
    for (int j = 0; j < DATA_W; j++) mflags[j] = model_bit(int'(d[DATA_W-1-j]));
    for (int j = 0; j < DATA_W; j++) begin
      c = (clr_rate != 0) && ($urandom_range(clr_rate - 1) == 0);
      clr  = c;
      stop = stop_mid && (j == 1);
      model_edge(mflags[j], c);
      @(negedge clk);
      clr = 1'b0; stop = 1'b0;
      if (j == DATA_W - 1) check_outs("last", mflags[j], !stop_mid, !stop_mid);
      else                 check_outs("bit", mflags[j], 1'b0, 1'b1);
    end
  endtask

  task automatic disarm_wait(input bit with_valid);
    stop = 1'b1;
    in_if.in_valid = with_valid;
    in_if.in_data  = DATA_W'($urandom);
    model_edge(1'b0, 1'b0);
    @(negedge clk);
    stop = 1'b0;
    check_outs("stopw", 1'b0, 1'b0, 1'b0);
    model_edge(1'b0, 1'b0);
    @(negedge clk);
    in_if.in_valid = 1'b0;
    check_outs("idle", 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [DATA_W-1:0] d;
    int nw;
    bit sm;
    in_if.in_valid = 1'b0;
    in_if.in_data  = '0;
    repeat (2) @(negedge clk);
    check_outs("rst", 1'b0, 1'b0, 1'b0);
    reset_ah_in = 1'b1;
    @(negedge clk);

    // non-overlap: two hits in 0xAA
    arm(4'b1010, 1'b0, 0);
    send_word(8'hAA, 1'b0, 0);
    chk("t1_cnt", 32'(match_cnt), 32'd2);

    // overlap: three hits
    pulse_clr();
    disarm_wait(1'b0);
    arm(4'b1010, 1'b1, 0);
    send_word(8'hAA, 1'b0, 0);
    chk("t2_cnt", 32'(match_cnt), 32'd3);

    // pattern spanning a word boundary
    disarm_wait(1'b0);
    arm(4'b1010, 1'b0, 0);
    pulse_clr();
    send_word(8'h01, 1'b0, 0);
    send_word(8'h40, 1'b0, 0);
    chk("t3_cnt", 32'(match_cnt), 32'd1);

    // threshold irq, clear, re-trigger
    disarm_wait(1'b0);
    arm(4'b1010, 1'b1, 3);
    pulse_clr();
    send_word(8'hAA, 1'b0, 0);
    chk("t4_irq", 32'(irq), 32'd1);
    pulse_clr();
    send_word(8'hAA, 1'b0, 0);
    chk("t4_irq2", 32'(irq), 32'd1);

    // stop inside a word, then stop racing a valid word in WAIT
    send_word(8'hAA, 1'b1, 0);
    arm(4'b1010, 1'b0, 0);
    disarm_wait(1'b1);

    // asynchronous reset in the middle of a word
    arm(4'b1010, 1'b1, 0);
    send_word(8'hAA, 1'b0, 0);
    in_if.in_valid = 1'b1;
    in_if.in_data  = 8'hAA;
    @(negedge clk);
    in_if.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1 reset_ah_in = 1'b0;
    #1;
    chk("ar_det",  32'(det_pulse),      32'd0);
    chk("ar_cnt",  32'(match_cnt),      32'd0);
    chk("ar_irq",  32'(irq),            32'd0);
    chk("ar_busy", 32'(busy),           32'd0);
    chk("ar_rdy",  32'(in_if.in_ready), 32'd0);
    m_cnt = 0; m_irq = 1'b0;
    @(negedge clk);
    reset_ah_in = 1'b1;
    @(negedge clk);
    arm(4'b1010, 1'b0, 0);
    send_word(8'hAA, 1'b0, 0);
    chk("t6_cnt", 32'(match_cnt), 32'd2);
    disarm_wait(1'b0);

    // randomized sessions
    for (int s = 0; s < 12; s++) begin
      if ($urandom_range(1) == 0) pulse_clr();
      arm(PAT_W'($urandom), 1'($urandom), $urandom_range(0, 5));
      nw = $urandom_range(2, 5);
      for (int w = 0; w < nw; w++) begin
        repeat ($urandom_range(0, 2)) wait_cycle(8);
        d  = ($urandom_range(2) == 0) ? DATA_W'({m_pat, m_pat}) : DATA_W'($urandom);
        sm = (w == nw - 1) && ($urandom_range(1) == 0);
        send_word(d, sm, 6);
        if (w == nw - 1 && !sm) disarm_wait(1'($urandom));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
